lpc_reg_arbiter: RTL

- Shares the LPC register-bank write/read port between the LPC host path and NUM_REQ internal requesters (e.g. BIOS-status sequencer, watchdog).
- Sits between the LPC decoder outputs and the register bank / read mux inside the LPC top level.
- Host writes have absolute priority and are never stalled.
- Internal requesters are served round-robin through a valid/ack handshake. Host reads bypass this block and go straight to the read mux.

---
 rtl/lpc_arb_pkg.sv | 32 +++
 rtl/lpc_rr_pick.sv | 33 +++
 rtl/lpc_reg_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lpc_arb_pkg.sv
// Shared types and helpers for the LPC register-port arbiter.
package lpc_arb_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int SLICE_VEC_W = 512;
    localparam int SLICE_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } arbState_t;

    // Field idx of a packed vector of equal-width fields, zero-extended.
    function automatic logic [SLICE_MAX_W-1:0] getSlice(
        input logic [SLICE_VEC_W-1:0] vec,
        input int                     idx,
        input int                     width
    );
        logic [SLICE_VEC_W-1:0] shifted;
        logic [SLICE_MAX_W-1:0] result;
        shifted = vec >> (idx * width);
        result  = '0;
        for (int b = 0; b < SLICE_MAX_W; b++) begin
            if (b < width) result[b] = shifted[b];
        end
        return result;
    endfunction

endpackage

// File: rtl/lpc_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module lpc_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grantIdx,
    output logic               grantValid
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;
    int                   idxSum;

    // Scan from the far end so the nearest requester after ptr is the last one written.
    always_comb begin
        doubled    = {reqVec, reqVec};
        rotated    = doubled >> ptr;
        grantIdx   = '0;
        grantValid = 1'b0;
        idxSum     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                idxSum = int'(ptr) + k;
                if (idxSum >= NUM_REQ) idxSum = idxSum - NUM_REQ;
                grantIdx   = IDX_W'(idxSum);
                grantValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Shares the LPC register-bank port between host writes (absolute priority)
// and NUM_REQ internal requesters served round-robin over valid/ack.
//
// state | meaning
// IDLE  | no internal access; arbitrate on ReqValid
// WR    | drive latched internal write unless a host write claims the port
// RD    | hold read address, wait RD_WAIT+1 cycles, then capture RegDataRd
// ACK   | ReqAck pulse to the granted requester, advance pointer
module lpc_reg_arbiter
    import lpc_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = 1
) (
    input  logic                        LpcClock,
    input  logic                        PciReset,
    input  logic                        HostWr,
    input  logic [ADDR_W-1:0]           HostAddr,
    input  logic [DATA_W-1:0]           HostData,
    input  logic [NUM_REQ-1:0]          ReqValid,
    input  logic [NUM_REQ-1:0]          ReqWrite,
    input  logic [NUM_REQ*ADDR_W-1:0]   ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0]   ReqData,
    output logic [NUM_REQ-1:0]          ReqAck,
    output logic [DATA_W-1:0]           RspData,
    input  logic [DATA_W-1:0]           RegDataRd,
    output logic                        RegWr,
    output logic [ADDR_W-1:0]           RegAddr,
    output logic [DATA_W-1:0]           RegDataWr,
    output logic                        Busy,
    output logic                        HostPreempt
);

    localparam int             IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int             CNT_W   = 4;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arbState_t         state;
    arbState_t         nextState;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  grantIdx;
    logic [IDX_W-1:0]  pickIdx;
    logic              pickValid;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latData;
    logic [CNT_W-1:0]  waitCnt;

    lpc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPick (
        .reqVec     (ReqValid),
        .ptr        (ptr),
        .grantIdx   (pickIdx),
        .grantValid (pickValid)
    );

    // The state itself carries the latched direction (WR vs RD).
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (pickValid) nextState = ReqWrite[pickIdx] ? WR : RD;
            WR:      if (!HostWr) nextState = ACK;
            RD:      if (!HostWr && waitCnt == '0) nextState = ACK;
            ACK:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge LpcClock or posedge PciReset) begin
        if (PciReset) begin
            state       <= IDLE;
            ptr         <= '0;
            grantIdx    <= '0;
            latAddr     <= '0;
            latData     <= '0;
            waitCnt     <= '0;
            ReqAck      <= '0;
            RspData     <= '0;
            RegWr       <= 1'b0;
            RegAddr     <= '0;
            RegDataWr   <= '0;
            Busy        <= 1'b0;
            HostPreempt <= 1'b0;
        end else begin
            state       <= nextState;
            Busy        <= (nextState != IDLE);
            RegWr       <= 1'b0;
            ReqAck      <= '0;
            HostPreempt <= 1'b0;

            case (state)
                IDLE: begin
                    if (pickValid) begin
                        grantIdx <= pickIdx;
                        latAddr  <= ADDR_W'(getSlice(SLICE_VEC_W'(ReqAddr), int'(pickIdx), ADDR_W));
                        latData  <= DATA_W'(getSlice(SLICE_VEC_W'(ReqData), int'(pickIdx), DATA_W));
                        waitCnt  <= RD_LOAD;
                    end
                end
                WR: begin
                    if (HostWr) begin
                        HostPreempt <= 1'b1;
                    end else begin
                        RegWr     <= 1'b1;
                        RegAddr   <= latAddr;
                        RegDataWr <= latData;
                        ReqAck    <= NUM_REQ'(1) << grantIdx;
                    end
                end
                RD: begin
                    // The count only runs while the read address is on the port.
                    if (HostWr) begin
                        HostPreempt <= 1'b1;
                        waitCnt     <= RD_LOAD;
                    end else begin
                        RegAddr <= latAddr;
                        if (waitCnt == '0) begin
                            RspData <= RegDataRd;
                            ReqAck  <= NUM_REQ'(1) << grantIdx;
                        end else begin
                            waitCnt <= waitCnt - CNT_W'(1);
                        end
                    end
                end
                ACK: begin
                    ptr <= (grantIdx == LAST_IDX) ? '0 : grantIdx + IDX_W'(1);
                end
                default: ;
            endcase

            // Host write wins the output register regardless of FSM state.
            if (HostWr) begin
                RegWr     <= 1'b1;
                RegAddr   <= HostAddr;
                RegDataWr <= HostData;
            end
        end
    end

endmodule
